pdm_demodulator: RTL

Recovers a WIDTH-bit level from a 1-bit pulse-density-modulated stream by counting ones over fixed 2^WIDTH-sample windows. It is the receive-side counterpart of the team's 5-bit PDM modulator. It closes the loop for on-chip loopback and external PDM sources, and exposes a registered level with a one-cycle valid strobe per window.

---
 rtl/pdm_pkg.sv | 14 +
 rtl/pdm_window_counter.sv | 42 ++++
 rtl/pdm_demodulator.sv | 66 ++++++
 3 files changed

// File: rtl/pdm_pkg.sv
// Shared PDM definitions: default level width, window length and the count clamp.
package pdm_pkg;

    localparam int unsigned PDM_WIDTH  = 5;
    localparam int unsigned PDM_WINDOW = 1 << PDM_WIDTH;

    // A full window of ones (count == 2^width) does not fit in width bits; pin it to the top code.
    function automatic int unsigned pdm_clamp(input int unsigned sum, input int unsigned width);
        int unsigned n;
        n = 32'(1) << width;
        return (sum >= n) ? n - 32'(1) : sum;
    endfunction

endpackage

// File: rtl/pdm_window_counter.sv
// Window phase/ones accumulator with sync restart; flags the window-end sample and its raw sum.
module pdm_window_counter
    import pdm_pkg::*;
#(
    parameter int unsigned WIDTH = PDM_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pdm_in,
    input  logic             sync,
    output logic             done_c,
    output logic [WIDTH:0]   sum_c
);

    localparam logic [WIDTH-1:0] PHASE_LAST = '1;

    logic [WIDTH-1:0] phase;
    logic [WIDTH:0]   acc;
    logic             last;

    assign last   = (phase == PHASE_LAST);
    assign sum_c  = acc + (WIDTH+1)'(pdm_in);
    // sync discards the window, so the window-end sample never strobes when sync is high
    assign done_c = last && !sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
            acc   <= '0;
        end else if (sync) begin
            phase <= WIDTH'(1);
            acc   <= (WIDTH+1)'(pdm_in);
        end else if (last) begin
            phase <= '0;
            acc   <= '0;
        end else begin
            phase <= phase + WIDTH'(1);
            acc   <= sum_c;
        end
    end

endmodule

// File: rtl/pdm_demodulator.sv
// PDM-to-level demodulator: counts ones per 2^WIDTH-sample window, registers level and strobe.
// Optional two-window averaging of the level when PDM_DEMOD_AVG_EN is defined.
module pdm_demodulator
    import pdm_pkg::*;
#(
    parameter int unsigned WIDTH = PDM_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pdm_in,
    input  logic             sync,
    output logic [WIDTH-1:0] value,
    output logic             valid,
    output logic             saturated
);

    logic             done_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] cur_c;
    logic [WIDTH-1:0] level_c;

    pdm_window_counter #(.WIDTH(WIDTH)) u_counter (
        .clk    (clk),
        .reset  (reset),
        .pdm_in (pdm_in),
        .sync   (sync),
        .done_c (done_c),
        .sum_c  (sum_c)
    );

    assign cur_c = WIDTH'(pdm_clamp(32'(sum_c), WIDTH));

`ifdef PDM_DEMOD_AVG_EN
    logic [WIDTH-1:0] prev;
    logic [WIDTH:0]   avg_sum_c;

    // Round half up; the sum of two clamped levels plus one always fits in WIDTH+1 bits
    assign avg_sum_c = {1'b0, prev} + {1'b0, cur_c} + (WIDTH+1)'(1);
    assign level_c   = WIDTH'(avg_sum_c >> 1);

    always_ff @(posedge clk) begin
        if (reset || sync) begin
            prev <= '0;
        end else if (done_c) begin
            prev <= cur_c;
        end
    end
`else
    assign level_c = cur_c;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            value     <= '0;
            valid     <= 1'b0;
            saturated <= 1'b0;
        end else begin
            valid <= done_c;
            if (done_c) begin
                value     <= level_c;
                saturated <= sum_c[WIDTH];
            end
        end
    end

endmodule
